// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_scan_ctrl_pkg;

    localparam int unsigned KEY_ROWS  = 4;
    localparam int unsigned KEY_COLS  = 4;
    localparam int unsigned KEY_COUNT = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE_DEB
    } scan_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } frame_class_t;

endpackage

// File: rtl/keypad_frame_classify.sv
// Classifies one completed scan frame: no key, exactly one key (with its code), or several keys.
module keypad_frame_classify
    import keypad_scan_ctrl_pkg::*;
(
    input  logic [15:0]  frame_map,
    output frame_class_t frame_class,
    output logic [3:0]   frame_code
);

    logic [1:0] hits;

    // Count set bits (saturating at 2) and remember the index of the first one.
    always_comb begin
        hits       = '0;
        frame_code = '0;
        for (int unsigned i = 0; i < KEY_COUNT; i++) begin
            if (frame_map[i]) begin
                if (hits == 2'd0) begin
                    frame_code = 4'(i);
                end
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
            end
        end
        case (hits)
            2'd0:    frame_class = NONE;
            2'd1:    frame_class = SINGLE;
            default: frame_class = MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column strobe, row synchroniser, frame debounce and ghost rejection.
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned TICK_MIN_GAP    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_tick,
    input  logic [3:0] keyboard_row,
    output logic [3:0] keyboard_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_release
);

    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || TICK_MIN_GAP < 3) begin : g_param_check
        $error("keypad_scan_ctrl: DEBOUNCE_FRAMES must be 1..15 and TICK_MIN_GAP >= 3");
    end

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

    logic [3:0]   row_meta;
    logic [3:0]   row_sync;
    logic [1:0]   col_idx;
    logic [1:0]   col_next;
    logic [15:0]  frame_map;
    logic [15:0]  sampled_map;
    logic         frame_end;
    frame_class_t frame_class;
    logic [3:0]   frame_code;

    scan_state_t  state, state_n;
    logic [3:0]   cnt, cnt_n, cnt_inc;
    logic [3:0]   cand, cand_n;
    logic [3:0]   code_n;
    logic         valid_n, down_n, release_n;

    // Two-flop synchroniser on the asynchronous row sense lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= keyboard_row;
            row_sync <= row_meta;
        end
    end

    assign col_next  = col_idx + 2'd1;
    assign frame_end = scan_tick && (col_idx == 2'd3);

    // Current map with this tick's column sample merged in; bit index = row*4 + col.
    always_comb begin
        sampled_map = frame_map;
        for (int unsigned r = 0; r < KEY_ROWS; r++) begin
            sampled_map[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    // Column strobe and frame map accumulation; the map clears once a frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx      <= '0;
            keyboard_col <= 4'b1110;
            frame_map    <= '0;
        end else if (scan_tick) begin
            col_idx      <= col_next;
            keyboard_col <= ~(4'b0001 << col_next);
            frame_map    <= frame_end ? '0 : sampled_map;
        end
    end

    keypad_frame_classify u_classify (
        .frame_map   (sampled_map),
        .frame_class (frame_class),
        .frame_code  (frame_code)
    );

    assign cnt_inc = (cnt >= DEB_N) ? DEB_N : cnt + 4'd1;

    // FSM state and registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_down    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cand        <= cand_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            key_down    <= down_n;
            key_release <= release_n;
        end
    end

    // Next-state evaluation, only at frame end. With DEBOUNCE_FRAMES=1 the
    // IDLE->DEBOUNCE->PRESSED (and PRESSED->RELEASE_DEB->IDLE) hops collapse into one frame.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cand_n    = cand;
        code_n    = key_code;
        valid_n   = 1'b0;
        down_n    = key_down;
        release_n = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (frame_class == SINGLE) begin
                        cand_n = frame_code;
                        if (DEB_N <= 4'd1) begin
                            state_n = PRESSED;
                            cnt_n   = '0;
                            code_n  = frame_code;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (frame_class == SINGLE && frame_code == cand) begin
                        if (cnt_inc >= DEB_N) begin
                            state_n = PRESSED;
                            cnt_n   = '0;
                            code_n  = cand;
                            valid_n = 1'b1;
                            down_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_class == NONE) begin
                        if (DEB_N <= 4'd1) begin
                            state_n   = IDLE;
                            cnt_n     = '0;
                            down_n    = 1'b0;
                            release_n = 1'b1;
                        end else begin
                            state_n = RELEASE_DEB;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                RELEASE_DEB: begin
                    if (frame_class == NONE) begin
                        if (cnt_inc >= DEB_N) begin
                            state_n   = IDLE;
                            cnt_n     = '0;
                            down_n    = 1'b0;
                            release_n = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 keypad matrix.
module tb_keypad_scan_ctrl;
    import keypad_scan_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_tick = 1'b0;
    logic [3:0]  keyboard_row;
    logic [3:0]  keyboard_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_down;
    logic        key_release;

    logic [15:0] keys = '0;
    int unsigned pass_cnt = 0;
    int unsigned fail_cnt = 0;
    int unsigned total = 0;
    int unsigned v_cnt = 0;
    int unsigned r_cnt = 0;
    logic [1:0]  tb_col = '0;
    logic        last_valid = 1'b0;
    logic        last_release = 1'b0;
    logic [3:0]  last_code = '0;

    localparam logic [15:0] K0  = 16'h0001;
    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] K7  = 16'h0080;
    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K12 = 16'h1000;
    localparam logic [15:0] K15 = 16'h8000;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .DEBOUNCE_FRAMES (3),
        .TICK_MIN_GAP    (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .scan_tick    (scan_tick),
        .keyboard_row (keyboard_row),
        .keyboard_col (keyboard_col),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_down     (key_down),
        .key_release  (key_release)
    );

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        keyboard_row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyboard_col[c] == 1'b0 && keys[r*4 + c]) begin
                    keyboard_row[r] = 1'b0;
                end
            end
        end
    end

    // Pulse counters.
    always @(negedge clk) begin
        if (key_valid === 1'b1) v_cnt++;
        if (key_release === 1'b1) r_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One column step: settle gap, one-cycle tick, then verify the column advanced.
    task automatic tick();
        logic [3:0] exp_col;
        repeat (3) @(negedge clk);
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        tb_col = tb_col + 2'd1;
        exp_col = ~(4'b0001 << tb_col);
        last_valid = key_valid;
        last_release = key_release;
        last_code = key_code;
        chk("col_seq", {12'h0, keyboard_col}, {12'h0, exp_col});
    endtask

    task automatic frame(input logic [15:0] k);
        keys = k;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_col", {12'h0, keyboard_col}, 16'h000E);
        chk("rst_valid", {15'h0, key_valid}, 16'h0);
        chk("rst_code", {12'h0, key_code}, 16'h0);
        chk("rst_down", {15'h0, key_down}, 16'h0);
        chk("rst_release", {15'h0, key_release}, 16'h0);
        chk("rst_state", {14'h0, dut.state}, {14'h0, IDLE});
        rst_n = 1'b1;

        // Ghosting: keys 0 and 15 together never produce an event
        for (int i = 0; i < 6; i++) frame(K0 | K15);
        chk("ghost_vcnt", 16'(v_cnt), 16'd0);
        chk("ghost_code", {12'h0, key_code}, 16'h0);
        chk("ghost_down", {15'h0, key_down}, 16'h0);
        chk("ghost_state", {14'h0, dut.state}, {14'h0, IDLE});

        // Clean press/release of code 9
        frame(K9); frame(K9);
        chk("p9_early", 16'(v_cnt), 16'd0);
        frame(K9);
        chk("p9_valid_at_fe", {15'h0, last_valid}, 16'h1);
        chk("p9_code_at_fe", {12'h0, last_code}, 16'h9);
        chk("p9_vcnt", 16'(v_cnt), 16'd1);
        chk("p9_down", {15'h0, key_down}, 16'h1);
        frame(K9); frame(K9);
        chk("p9_held_vcnt", 16'(v_cnt), 16'd1);
        frame('0); frame('0);
        chk("r9_down_hold", {15'h0, key_down}, 16'h1);
        chk("r9_early_rel", 16'(r_cnt), 16'd0);
        frame('0);
        chk("r9_rel_at_fe", {15'h0, last_release}, 16'h1);
        chk("r9_down_off", {15'h0, key_down}, 16'h0);
        chk("r9_rcnt", 16'(r_cnt), 16'd1);
        chk("r9_code_hold", {12'h0, key_code}, 16'h9);
        frame('0); frame('0);
        chk("r9_rcnt_stay", 16'(r_cnt), 16'd1);
        chk("r9_vcnt_stay", 16'(v_cnt), 16'd1);

        // Bounce: 5,5,none,5,5,5
        frame(K5); frame(K5); frame('0); frame(K5); frame(K5);
        chk("b5_early", 16'(v_cnt), 16'd1);
        frame(K5);
        chk("b5_valid_at_fe", {15'h0, last_valid}, 16'h1);
        chk("b5_code", {12'h0, key_code}, 16'h5);
        chk("b5_vcnt", 16'(v_cnt), 16'd2);
        frame('0); frame('0); frame('0);
        chk("b5_rcnt", 16'(r_cnt), 16'd2);
        chk("b5_down_off", {15'h0, key_down}, 16'h0);

        // Held key plus a second key
        frame(K3); frame(K3); frame(K3);
        chk("h3_vcnt", 16'(v_cnt), 16'd3);
        chk("h3_code", {12'h0, key_code}, 16'h3);
        for (int i = 0; i < 4; i++) frame(K3 | K12);
        chk("h12_vcnt", 16'(v_cnt), 16'd3);
        chk("h12_down", {15'h0, key_down}, 16'h1);
        chk("h12_code", {12'h0, key_code}, 16'h3);
        frame(K3);
        chk("h3b_vcnt", 16'(v_cnt), 16'd3);
        chk("h3b_rcnt", 16'(r_cnt), 16'd2);
        frame('0); frame('0);
        chk("h_rel_early", 16'(r_cnt), 16'd2);
        chk("h_down_hold", {15'h0, key_down}, 16'h1);
        frame('0);
        chk("h_rel_at_fe", {15'h0, last_release}, 16'h1);
        chk("h_rcnt", 16'(r_cnt), 16'd3);
        chk("h_down_off", {15'h0, key_down}, 16'h0);

        // Release bounce on code 7
        frame(K7); frame(K7); frame(K7);
        chk("p7_vcnt", 16'(v_cnt), 16'd4);
        chk("p7_code", {12'h0, key_code}, 16'h7);
        frame('0); frame('0);
        chk("rb7_rcnt_a", 16'(r_cnt), 16'd3);
        chk("rb7_down_a", {15'h0, key_down}, 16'h1);
        frame(K7);
        chk("rb7_vcnt", 16'(v_cnt), 16'd4);
        chk("rb7_state", {14'h0, dut.state}, {14'h0, PRESSED});
        frame('0); frame('0);
        chk("rb7_rcnt_b", 16'(r_cnt), 16'd3);
        frame('0);
        chk("rb7_rel_at_fe", {15'h0, last_release}, 16'h1);
        chk("rb7_rcnt_c", 16'(r_cnt), 16'd4);
        chk("rb7_vcnt_c", 16'(v_cnt), 16'd4);
        chk("rb7_down_off", {15'h0, key_down}, 16'h0);

        // Reset mid-scan while PRESSED
        frame(K9); frame(K9); frame(K9);
        chk("mr_vcnt", 16'(v_cnt), 16'd5);
        chk("mr_state", {14'h0, dut.state}, {14'h0, PRESSED});
        keys = K9;
        tick(); tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_col", {12'h0, keyboard_col}, 16'h000E);
        chk("mr_down", {15'h0, key_down}, 16'h0);
        chk("mr_valid", {15'h0, key_valid}, 16'h0);
        chk("mr_release", {15'h0, key_release}, 16'h0);
        chk("mr_code", {12'h0, key_code}, 16'h0);
        chk("mr_st_idle", {14'h0, dut.state}, {14'h0, IDLE});
        tb_col = '0;
        keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frame('0);
        chk("mr_post_vcnt", 16'(v_cnt), 16'd5);
        chk("mr_post_rcnt", 16'(r_cnt), 16'd4);
        chk("mr_post_down", {15'h0, key_down}, 16'h0);
        frame(K9); frame(K9); frame(K9);
        chk("mr_again_vcnt", 16'(v_cnt), 16'd6);
        chk("mr_again_code", {12'h0, key_code}, 16'h9);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad on keyboard_col/keyboard_row. It strobes one column at a time and samples the rows through a synchroniser. It debounces whole scan frames and rejects multi-key (ghosting) frames. Output is one clean key event (code plus 1-cycle valid pulse) per press, plus a held level and a release pulse. The game controller consumes these outputs.

Parameters:
DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a press or a release (range 1..15)
TICK_MIN_GAP, 3, minimum clk cycles between scan_tick pulses; documents the synchroniser constraint only, no logic depends on it

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
scan_tick  input  1  one-cycle enable pulse, one column step per pulse (e.g. 400 Hz, giving a 100 Hz frame rate)
keyboard_row  input  4  row sense lines, active-low (0 = key pressed on the driven column), asynchronous to clk
keyboard_col  output  4  column drive, one-hot active-low
key_valid  output  1  one-cycle pulse when a press is accepted
key_code  output  4  accepted key, = row_idx*4 + col_idx; stable until the next key_valid
key_down  output  1  high from the key_valid cycle until the release is accepted
key_release  output  1  one-cycle pulse when a release is accepted

Behaviour:
- Reset (async, rst_n=0) values:
  - keyboard_col=4'b1110 (col_idx 0); key_valid=0, key_code=0, key_down=0, key_release=0
  - FSM=IDLE; debounce count=0; frame map=0; synchroniser flops=4'b1111
- Row input: 2-flop synchroniser on keyboard_row. scan_tick pulses must be >=TICK_MIN_GAP clk apart; at a closer spacing the sampled data is undefined, but the FSM must never leave its legal state set.
- Column scan, on each scan_tick:
  - record ~row_sync into map bits [col_idx] of all four rows
  - then advance col_idx 0->1->2->3->0
  - keyboard_col = ~(1<<col_idx), registered
- Frame end is the scan_tick at col_idx==3. The frame is classified from the completed 16-bit map, including the col-3 sample taken that same tick:
  - NONE: map==0
  - SINGLE(c): exactly one bit set, c = its index
  - MULTI: two or more bits set
  - The map clears for the next frame.
- FSM evaluates only at frame end:
  - IDLE: SINGLE(c) -> DEBOUNCE, cand=c, cnt=1. NONE or MULTI -> stay.
  - DEBOUNCE: SINGLE(cand) -> cnt+1. Any other class -> IDLE, cnt=0. When cnt reaches DEBOUNCE_FRAMES -> PRESSED, with key_code=cand, key_valid pulse, key_down=1.
  - PRESSED: NONE -> RELEASE_DEB, cnt=1. Any other class -> stay. Extra keys or a key change while held produce no new event.
  - RELEASE_DEB: NONE -> cnt+1; when cnt reaches DEBOUNCE_FRAMES -> IDLE, with key_down=0 and key_release pulse. Any key -> PRESSED, cnt=0, no new event.
- DEBOUNCE_FRAMES=1: accept on the first qualifying frame. IDLE->DEBOUNCE->PRESSED then happens within one frame-end evaluation, i.e. the DEBOUNCE threshold check uses the incremented count.
- Latency: key_valid and key_release are registered and assert the clk cycle after the qualifying frame-end scan_tick, high for exactly 1 clk.
- key_code holds its value through release and IDLE; it changes only together with key_valid.
- The counter saturates at DEBOUNCE_FRAMES and never wraps.
- No back-pressure: the consumer must sample on key_valid.

Decomposition:
- Shared package: FSM state enum (IDLE, DEBOUNCE, PRESSED, RELEASE_DEB); frame class enum (NONE, SINGLE, MULTI); KEY_ROWS=4, KEY_COLS=4 constants.
- One natural sub-module: keypad_frame_classify (combinational: 16-bit map -> class + 4-bit code). Column counter, synchroniser and FSM stay in the top of the block.

Test Plan:
- Reset: assert rst_n=0 mid-scan while in PRESSED -> keyboard_col=1110, key_down=0, no pulses; first frame after release of reset starts at col 0.
- Clean press/release: hold row 2 low only while col 1 is driven (code 9) for 5 frames, then release for 5 frames, DEBOUNCE_FRAMES=3 -> exactly one key_valid with key_code=9 one clk after the 3rd frame end; key_down high until 1 clk after the 3rd empty frame end; exactly one key_release pulse.
- Bounce: code 5 for 2 frames, NONE for 1, code 5 for 3 -> single key_valid (code 5) only after the final 3-frame run; no pulse earlier.
- Ghosting: codes 0 and 15 pressed together for 6 frames -> no key_valid, FSM stays IDLE, key_code remains 0.
- Held + second key: press code 3 (accepted), then add code 12 for 4 frames, then release 12 -> no second key_valid; key_down stays 1; no key_release until all keys are up for 3 frames.
- Release bounce: in PRESSED with code 7, NONE 2 frames, code 7 1 frame, NONE 3 frames -> no new key_valid; key_release only after the final 3-frame NONE run; column sequence 1110,1101,1011,0111 verified on every scan_tick.
